proc_sched: RTL and testbench

PROC_SCHED -- requirements
Module: proc_sched

---
 rtl/proc_sched_pkg.sv | 24 ++
 rtl/proc_sched_if.sv | 52 +++++
 rtl/proc_slot.sv | 82 ++++++++
 rtl/proc_sched.sv | 128 ++++++++++++
 tb/tb_proc_sched.sv | 309 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/proc_sched_pkg.sv
// -----------------------------------------------------------------------------
// proc_sched_pkg
// Shared types and constants for the job-slot scheduler.
//   slot_state_t : per-slot lifecycle state, encoded exactly as it appears on
//                  the 2-bit-per-slot status bus.
//   N_JOBS_DEF   : default number of job slots.
//   is_terminal  : true for the states a job can end in (FINISHED/KILLED).
// -----------------------------------------------------------------------------
package proc_sched_pkg;

    localparam int N_JOBS_DEF = 8;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUNNING  = 2'd1,
        S_FINISHED = 2'd2,
        S_KILLED   = 2'd3
    } slot_state_t;

    function automatic logic is_terminal(input slot_state_t st);
        return (st == S_FINISHED) || (st == S_KILLED);
    endfunction

endpackage

// File: rtl/proc_sched_if.sv
// -----------------------------------------------------------------------------
// proc_sched_if
// Bundles every scheduler-facing signal except clock and reset.
//   slave  : the scheduler side (proc_sched)
//   master : the client side (spawner / workers / supervisor)
// Signals:
//   spawn_valid/spawn_ready/spawn_id : job creation handshake + granted slot
//   start[k] / abort[k]              : one-cycle pulses to worker k
//   done[k]                          : worker k finished pulse
//   kill_valid/kill_id, kill_all     : kill one slot / every running slot
//   await_valid/await_id             : wait on one slot
//   await_busy/await_done            : wait in progress / wait completed pulse
//   reap_valid/reap_id               : return a terminal slot to IDLE
//   status                           : 2 bits per slot, slot k at [2k+1:2k]
// -----------------------------------------------------------------------------
interface proc_sched_if
    import proc_sched_pkg::*;
#(
    parameter int N_JOBS = N_JOBS_DEF,
    parameter int ID_W   = $clog2(N_JOBS)
);
    logic                  spawn_valid;
    logic                  spawn_ready;
    logic [ID_W-1:0]       spawn_id;
    logic [N_JOBS-1:0]     start;
    logic [N_JOBS-1:0]     done;
    logic                  kill_valid;
    logic [ID_W-1:0]       kill_id;
    logic                  kill_all;
    logic [N_JOBS-1:0]     abort;
    logic                  await_valid;
    logic [ID_W-1:0]       await_id;
    logic                  await_busy;
    logic                  await_done;
    logic                  reap_valid;
    logic [ID_W-1:0]       reap_id;
    logic [2*N_JOBS-1:0]   status;

    modport slave (
        input  spawn_valid, done, kill_valid, kill_id, kill_all,
               await_valid, await_id, reap_valid, reap_id,
        output spawn_ready, spawn_id, start, abort, await_busy, await_done,
               status
    );

    modport master (
        output spawn_valid, done, kill_valid, kill_id, kill_all,
               await_valid, await_id, reap_valid, reap_id,
        input  spawn_ready, spawn_id, start, abort, await_busy, await_done,
               status
    );
endinterface

// File: rtl/proc_slot.sv
// -----------------------------------------------------------------------------
// proc_slot
// Lifecycle FSM for a single job slot: IDLE -> RUNNING -> FINISHED|KILLED -> IDLE.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_spawn    : this slot was granted to an accepted spawn
//   i_done     : worker finished pulse
//   i_kill     : kill request (single-slot or broadcast, already decoded)
//   i_reap     : reap request (already gated against a pending await)
//   o_state    : registered slot state
//   o_start    : one-cycle pulse in the first RUNNING cycle
//   o_abort    : one-cycle pulse in the first KILLED cycle
// -----------------------------------------------------------------------------
module proc_slot
    import proc_sched_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_spawn,
    input  logic        i_done,
    input  logic        i_kill,
    input  logic        i_reap,
    output slot_state_t o_state,
    output logic        o_start,
    output logic        o_abort
);

    slot_state_t r_state;
    slot_state_t w_state_next;
    logic        r_start;
    logic        r_abort;
    logic        w_start_next;
    logic        w_abort_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_abort <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_start <= w_start_next;
            r_abort <= w_abort_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_start_next = 1'b0;
        w_abort_next = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_spawn) begin
                    w_state_next = S_RUNNING;
                    w_start_next = 1'b1;
                end
            end
            S_RUNNING: begin
                // A finish that races a kill wins: the work completed.
                if (i_done) begin
                    w_state_next = S_FINISHED;
                end else if (i_kill) begin
                    w_state_next = S_KILLED;
                    w_abort_next = 1'b1;
                end
            end
            S_FINISHED, S_KILLED: begin
                if (i_reap) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign o_state = r_state;
    assign o_start = r_start;
    assign o_abort = r_abort;

endmodule

// File: rtl/proc_sched.sv
// -----------------------------------------------------------------------------
// proc_sched
// Job-slot scheduler: allocates the lowest free slot on spawn, fans kill/reap
// requests out to per-slot FSMs and tracks a single outstanding await.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : proc_sched_if.slave (spawn, start/done, kill, abort, await, reap,
//          status)
// -----------------------------------------------------------------------------
module proc_sched
    import proc_sched_pkg::*;
#(
    parameter int N_JOBS = N_JOBS_DEF,
    parameter int ID_W   = $clog2(N_JOBS)
)(
    input  logic        clk,
    input  logic        rst,
    proc_sched_if.slave bus
);

    slot_state_t         w_state [N_JOBS];
    logic [N_JOBS-1:0]   w_start;
    logic [N_JOBS-1:0]   w_abort;
    logic [N_JOBS-1:0]   w_spawn_go;
    logic [N_JOBS-1:0]   w_kill;
    logic [N_JOBS-1:0]   w_reap;
    logic [N_JOBS-1:0]   w_reap_block;
    logic [2*N_JOBS-1:0] w_status;

    logic                w_any_idle;
    logic [ID_W-1:0]     w_spawn_id;
    logic                w_spawn_accept;

    logic                r_await_busy;
    logic [ID_W-1:0]     r_await_id;
    logic                w_await_term;
    logic                w_await_done;
    logic                w_await_busy;
    logic                w_await_accept;

    // Lowest-index IDLE slot, from registered state only, so a slot being
    // reaped this cycle can never be handed out in the same cycle.
    always_comb begin
        w_any_idle = 1'b0;
        w_spawn_id = '0;
        for (int i = N_JOBS - 1; i >= 0; i--) begin
            if (w_state[i] == S_IDLE) begin
                w_any_idle = 1'b1;
                w_spawn_id = ID_W'(i);
            end
        end
    end

    assign w_spawn_accept = bus.spawn_valid && w_any_idle;

    // Terminal check on the awaited slot, written as a search so an id
    // beyond N_JOBS simply never completes instead of indexing out of range.
    always_comb begin
        w_await_term = 1'b0;
        for (int i = 0; i < N_JOBS; i++) begin
            if (r_await_id == ID_W'(i)) begin
                w_await_term = is_terminal(w_state[i]);
            end
        end
    end

    // Completion is decoded combinationally from registered state so the pulse
    // lands in the first cycle the slot shows as terminal; busy drops in that
    // same cycle, which also lets a new await be accepted right away.
    assign w_await_done   = r_await_busy && w_await_term;
    assign w_await_busy   = r_await_busy && !w_await_done;
    assign w_await_accept = bus.await_valid && !w_await_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_await_busy <= 1'b0;
            r_await_id   <= '0;
        end else if (w_await_accept) begin
            r_await_busy <= 1'b1;
            r_await_id   <= bus.await_id;
        end else if (w_await_done) begin
            r_await_busy <= 1'b0;
        end
    end

    generate
        for (genvar gi = 0; gi < N_JOBS; gi++) begin : g_slot
            assign w_spawn_go[gi] = w_spawn_accept && (w_spawn_id == ID_W'(gi));

            // kill_all reaches every slot; only RUNNING slots act on it, so a
            // slot that is still IDLE while being spawned is left alone.
            assign w_kill[gi] = (bus.kill_valid && (bus.kill_id == ID_W'(gi)))
                              || bus.kill_all;

            // A slot that is (or is just becoming) the await target must keep
            // its terminal state until the waiter has seen it.
            assign w_reap_block[gi] = (w_await_busy && (r_await_id == ID_W'(gi)))
                                    || (w_await_accept && (bus.await_id == ID_W'(gi)));

            assign w_reap[gi] = bus.reap_valid && (bus.reap_id == ID_W'(gi))
                              && !w_reap_block[gi];

            proc_slot u_slot (
                .clk     (clk),
                .rst     (rst),
                .i_spawn (w_spawn_go[gi]),
                .i_done  (bus.done[gi]),
                .i_kill  (w_kill[gi]),
                .i_reap  (w_reap[gi]),
                .o_state (w_state[gi]),
                .o_start (w_start[gi]),
                .o_abort (w_abort[gi])
            );

            assign w_status[2*gi +: 2] = w_state[gi];
        end
    endgenerate

    assign bus.spawn_ready = w_any_idle;
    assign bus.spawn_id    = w_spawn_id;
    assign bus.start       = w_start;
    assign bus.abort       = w_abort;
    assign bus.await_busy  = w_await_busy;
    assign bus.await_done  = w_await_done;
    assign bus.status      = w_status;

endmodule

// File: tb/tb_proc_sched.sv
// -----------------------------------------------------------------------------
// tb_proc_sched
// Directed bench for proc_sched (N_JOBS=8). Stimulus queues expected start,
// abort and await_done pulses tagged with the cycle they must appear in; a
// negedge monitor pops and compares every pulse the DUT produces. Slot states
// and handshake levels are checked directly after each step.
// -----------------------------------------------------------------------------
module tb_proc_sched;

    localparam int NJ = 8;
    localparam int IW = 3;

    typedef struct {
        int         cyc;
        logic [7:0] vec;
    } ev_t;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    logic mon_en;

    ev_t  q_start[$];
    ev_t  q_abort[$];
    ev_t  q_await[$];
    ev_t  m_ev;

    proc_sched_if #(.N_JOBS(NJ), .ID_W(IW)) bus ();

    proc_sched #(.N_JOBS(NJ), .ID_W(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "watchdog");
    end

    // ---------------------------------------------------------------- monitor
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.start != '0) begin
                n_cmp++;
                if (q_start.size() == 0) begin
                    n_bad++;
                    $display("FAIL start: got %b at cycle %0d, required no pulse", bus.start, cyc);
                end else begin
                    m_ev = q_start.pop_front();
                    if (m_ev.vec !== bus.start || m_ev.cyc != cyc) begin
                        n_bad++;
                        $display("FAIL start: got %b at cycle %0d, required %b at cycle %0d",
                                 bus.start, cyc, m_ev.vec, m_ev.cyc);
                    end else
                        $display("[cyc %0d] start %b ok", cyc, bus.start);
                end
            end
            if (bus.abort != '0) begin
                n_cmp++;
                if (q_abort.size() == 0) begin
                    n_bad++;
                    $display("FAIL abort: got %b at cycle %0d, required no pulse", bus.abort, cyc);
                end else begin
                    m_ev = q_abort.pop_front();
                    if (m_ev.vec !== bus.abort || m_ev.cyc != cyc) begin
                        n_bad++;
                        $display("FAIL abort: got %b at cycle %0d, required %b at cycle %0d",
                                 bus.abort, cyc, m_ev.vec, m_ev.cyc);
                    end else
                        $display("[cyc %0d] abort %b ok", cyc, bus.abort);
                end
            end
            if (bus.await_done) begin
                n_cmp++;
                if (q_await.size() == 0) begin
                    n_bad++;
                    $display("FAIL await_done: got pulse at cycle %0d, required no pulse", cyc);
                end else begin
                    m_ev = q_await.pop_front();
                    if (m_ev.cyc != cyc) begin
                        n_bad++;
                        $display("FAIL await_done: got pulse at cycle %0d, required at cycle %0d",
                                 cyc, m_ev.cyc);
                    end else
                        $display("[cyc %0d] await_done ok", cyc);
                end
            end
        end
    end

    // ---------------------------------------------------------------- helpers
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end else
            $display("[cyc %0d] %s = 0x%0h ok", cyc, name, act);
    endtask

    function automatic logic [1:0] slot_st(input int k);
        return bus.status[2*k +: 2];
    endfunction

    task automatic push_start(input logic [7:0] v);
        q_start.push_back('{cyc: cyc + 1, vec: v});
    endtask

    task automatic push_abort(input logic [7:0] v);
        q_abort.push_back('{cyc: cyc + 1, vec: v});
    endtask

    task automatic push_await();
        q_await.push_back('{cyc: cyc + 1, vec: 8'h01});
    endtask

    task automatic do_reap(input int k);
        bus.reap_valid = 1'b1;
        bus.reap_id    = IW'(k);
        step();
        bus.reap_valid = 1'b0;
    endtask

    task automatic do_spawn(input int k);
        bus.spawn_valid = 1'b1;
        push_start(8'(1 << k));
        step();
        bus.spawn_valid = 1'b0;
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        cyc    = 0;
        n_cmp  = 0;
        n_bad  = 0;
        mon_en = 1'b0;
        rst    = 1'b1;
        bus.spawn_valid = 1'b0;
        bus.done        = '0;
        bus.kill_valid  = 1'b0;
        bus.kill_id     = '0;
        bus.kill_all    = 1'b0;
        bus.await_valid = 1'b0;
        bus.await_id    = '0;
        bus.reap_valid  = 1'b0;
        bus.reap_id     = '0;

        step();
        step();
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("reset status", 32'(bus.status), 32'h0);
        chk("reset spawn_ready", 32'(bus.spawn_ready), 32'h1);
        chk("reset spawn_id", 32'(bus.spawn_id), 32'h0);
        chk("reset await_busy", 32'(bus.await_busy), 32'h0);

        // Eight back-to-back spawns fill slots 0..7 in order.
        bus.spawn_valid = 1'b1;
        for (int i = 0; i < NJ; i++) begin
            chk($sformatf("spawn_id #%0d", i), 32'(bus.spawn_id), 32'(i));
            push_start(8'(1 << i));
            step();
        end
        bus.spawn_valid = 1'b0;
        chk("full spawn_ready", 32'(bus.spawn_ready), 32'h0);
        chk("all running", 32'(bus.status), 32'h5555);

        // Await slot 1, then finish it.
        bus.await_valid = 1'b1;
        bus.await_id    = 3'd1;
        step();
        bus.await_valid = 1'b0;
        chk("await_busy set", 32'(bus.await_busy), 32'h1);
        bus.done = 8'h02;
        push_await();
        step();
        bus.done = '0;
        chk("slot1 finished", 32'(slot_st(1)), 32'h2);
        chk("await_busy cleared", 32'(bus.await_busy), 32'h0);

        // kill_all: everyone but the finished slot 1 is aborted.
        bus.kill_all = 1'b1;
        push_abort(8'hFD);
        step();
        bus.kill_all = 1'b0;
        chk("after kill_all", 32'(bus.status), 32'hFFFB);

        // Recycle slot 3, then race done against kill on it.
        do_reap(3);
        chk("slot3 reaped", 32'(slot_st(3)), 32'h0);
        chk("spawn_id after reap 3", 32'(bus.spawn_id), 32'h3);
        do_spawn(3);
        chk("slot3 running", 32'(slot_st(3)), 32'h1);
        bus.done       = 8'h08;
        bus.kill_valid = 1'b1;
        bus.kill_id    = 3'd3;
        step();
        bus.done       = '0;
        bus.kill_valid = 1'b0;
        chk("slot3 done beats kill", 32'(slot_st(3)), 32'h2);

        // Kill on a FINISHED slot and done on a KILLED slot are ignored.
        bus.kill_valid = 1'b1;
        bus.kill_id    = 3'd1;
        step();
        bus.kill_valid = 1'b0;
        chk("kill finished ignored", 32'(slot_st(1)), 32'h2);
        bus.done = 8'h04;
        step();
        bus.done = '0;
        chk("done on killed ignored", 32'(slot_st(2)), 32'h3);

        // Single kill of a running slot.
        do_reap(0);
        do_spawn(0);
        bus.kill_valid = 1'b1;
        bus.kill_id    = 3'd0;
        push_abort(8'h01);
        step();
        bus.kill_valid = 1'b0;
        chk("slot0 killed", 32'(slot_st(0)), 32'h3);

        // Reap slot 5 frees it; reap of a running slot is ignored.
        do_reap(5);
        chk("slot5 idle", 32'(slot_st(5)), 32'h0);
        chk("spawn_ready after reap 5", 32'(bus.spawn_ready), 32'h1);
        chk("spawn_id after reap 5", 32'(bus.spawn_id), 32'h5);
        do_spawn(5);
        do_reap(5);
        chk("reap running ignored", 32'(slot_st(5)), 32'h1);

        // Await 5; a second await while busy (on terminal slot 2) is dropped.
        bus.await_valid = 1'b1;
        bus.await_id    = 3'd5;
        step();
        bus.await_id    = 3'd2;
        step();
        bus.await_valid = 1'b0;
        chk("busy holds", 32'(bus.await_busy), 32'h1);
        bus.done = 8'h20;
        push_await();
        step();
        bus.done = '0;
        chk("slot5 finished", 32'(slot_st(5)), 32'h2);
        chk("busy cleared 5", 32'(bus.await_busy), 32'h0);

        // Await a terminal slot with a same-cycle reap: the reap is held off.
        bus.await_valid = 1'b1;
        bus.await_id    = 3'd4;
        bus.reap_valid  = 1'b1;
        bus.reap_id     = 3'd4;
        push_await();
        step();
        bus.await_valid = 1'b0;
        bus.reap_valid  = 1'b0;
        chk("reap blocked by await", 32'(slot_st(4)), 32'h3);
        do_reap(4);
        chk("reap after await_done", 32'(slot_st(4)), 32'h0);

        // Fresh start: four running jobs and a pending await, then reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) do_spawn(i);
        chk("four running", 32'(bus.status), 32'h0055);
        bus.await_valid = 1'b1;
        bus.await_id    = 3'd2;
        step();
        bus.await_valid = 1'b0;
        chk("await pending", 32'(bus.await_busy), 32'h1);
        rst          = 1'b1;
        bus.kill_all = 1'b1;
        bus.done     = 8'hFF;
        step();
        rst          = 1'b0;
        bus.kill_all = 1'b0;
        bus.done     = '0;
        chk("mid reset status", 32'(bus.status), 32'h0);
        chk("mid reset busy", 32'(bus.await_busy), 32'h0);
        chk("mid reset spawn_ready", 32'(bus.spawn_ready), 32'h1);
        chk("mid reset spawn_id", 32'(bus.spawn_id), 32'h0);

        for (int i = 0; i < 4; i++) step();

        chk("start events left", 32'(q_start.size()), 32'h0);
        chk("abort events left", 32'(q_abort.size()), 32'h0);
        chk("await events left", 32'(q_await.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
